// File: rtl/ext_bus_arbiter.sv
// Two-requester arbiter for an 8-bit external asynchronous bus with a pad 3-state buffer.
// Define EXT_BUS_FAIRNESS_EN for round-robin arbitration; otherwise requester A has fixed priority.
module ext_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_tristate,
  output logic        bus_we_n,
  output logic        bus_oe_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        win_b_q, win_b_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        bus_tristate_q, bus_tristate_d;
  logic        bus_we_n_q, bus_we_n_d;
  logic        bus_oe_n_q, bus_oe_n_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        grant_b;

`ifdef EXT_BUS_FAIRNESS_EN
  logic        last_b_q, last_b_d;

  // On a tie, B wins only when A was the last requester granted.
  always_comb begin
    grant_b = b_req && (!a_req || !last_b_q);
  end
`else
  always_comb begin
    grant_b = b_req && !a_req;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    win_b_d    = win_b_q;
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;
    rdata_d    = rdata_q;
`ifdef EXT_BUS_FAIRNESS_EN
    last_b_d   = last_b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d    = SETUP;
          win_b_d    = grant_b;
          we_d       = grant_b ? b_we : a_we;
          bus_addr_d = grant_b ? b_addr : a_addr;
          bus_dout_d = grant_b ? b_wdata : a_wdata;
          cnt_d      = WAIT_LD;
`ifdef EXT_BUS_FAIRNESS_EN
          last_b_d   = grant_b;
`endif
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = TURN;
          if (!we_q) rdata_d = bus_din;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    bus_tristate_d = !(we_d && (state_d == SETUP || state_d == ACCESS));
    bus_we_n_d     = !(we_d && state_d == ACCESS);
    bus_oe_n_d     = !(!we_d && (state_d == SETUP || state_d == ACCESS));
    a_ack_d        = (state_d == TURN) && !win_b_d;
    b_ack_d        = (state_d == TURN) && win_b_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      win_b_q        <= 1'b0;
      bus_addr_q     <= '0;
      bus_dout_q     <= '0;
      rdata_q        <= '0;
      bus_tristate_q <= 1'b1;
      bus_we_n_q     <= 1'b1;
      bus_oe_n_q     <= 1'b1;
      a_ack_q        <= 1'b0;
      b_ack_q        <= 1'b0;
`ifdef EXT_BUS_FAIRNESS_EN
      last_b_q       <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      win_b_q        <= win_b_d;
      bus_addr_q     <= bus_addr_d;
      bus_dout_q     <= bus_dout_d;
      rdata_q        <= rdata_d;
      bus_tristate_q <= bus_tristate_d;
      bus_we_n_q     <= bus_we_n_d;
      bus_oe_n_q     <= bus_oe_n_d;
      a_ack_q        <= a_ack_d;
      b_ack_q        <= b_ack_d;
`ifdef EXT_BUS_FAIRNESS_EN
      last_b_q       <= last_b_d;
`endif
    end
  end

  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign rdata        = rdata_q;
  assign bus_addr     = bus_addr_q;
  assign bus_dout     = bus_dout_q;
  assign bus_tristate = bus_tristate_q;
  assign bus_we_n     = bus_we_n_q;
  assign bus_oe_n     = bus_oe_n_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Self-checking bench for ext_bus_arbiter: directed scenarios then randomized transactions
// checked cycle by cycle against a transaction-level model of the bus protocol.
module tb_ext_bus_arbiter;

  localparam int W = 2;
`ifdef EXT_BUS_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk, reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [7:0]  rdata, bus_dout, bus_din;
  logic [15:0] bus_addr;
  logic        bus_tristate, bus_we_n, bus_oe_n;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_rdata;
  bit         m_last_b;

  ext_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_tristate(bus_tristate), .bus_we_n(bus_we_n), .bus_oe_n(bus_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tri"}, 32'(bus_tristate), 32'd1);
    chk({tag, " we_n"}, 32'(bus_we_n), 32'd1);
    chk({tag, " oe_n"}, 32'(bus_oe_n), 32'd1);
    chk({tag, " a_ack"}, 32'(a_ack), 32'd0);
    chk({tag, " b_ack"}, 32'(b_ack), 32'd0);
    chk({tag, " rdata"}, 32'(rdata), 32'(m_rdata));
  endtask

  // Called with the DUT idle and requests already applied; returns one cycle after ack.
  task automatic run_txn(input bit drop_mid, output bit got_b);
    bit          wb, we;
    logic [15:0] addr;
    logic [7:0]  wd, din, exp_rd;
    bit          drive, strobe, oe;
    if (a_req && b_req) wb = FAIR && !m_last_b;
    else                wb = b_req;
    m_last_b = wb;
    we   = wb ? b_we : a_we;
    addr = wb ? b_addr : a_addr;
    wd   = wb ? b_wdata : a_wdata;
    din  = bus_din;
    got_b = 1'b0;
    for (int k = 1; k <= W + 2; k++) begin
      @(posedge clk); #1;
      if (drop_mid && k == 1) begin a_req = 1'b0; b_req = 1'b0; end
      drive  = we && k <= W + 1;
      strobe = we && k >= 2 && k <= W + 1;
      oe     = !we && k <= W + 1;
      exp_rd = (k == W + 2 && !we) ? din : m_rdata;
      chk($sformatf("tri k%0d", k), 32'(bus_tristate), 32'(!drive));
      chk($sformatf("we_n k%0d", k), 32'(bus_we_n), 32'(!strobe));
      chk($sformatf("oe_n k%0d", k), 32'(bus_oe_n), 32'(!oe));
      chk($sformatf("a_ack k%0d", k), 32'(a_ack), 32'(k == W + 2 && !wb));
      chk($sformatf("b_ack k%0d", k), 32'(b_ack), 32'(k == W + 2 && wb));
      chk($sformatf("addr k%0d", k), 32'(bus_addr), 32'(addr));
      chk($sformatf("dout k%0d", k), 32'(bus_dout), 32'(wd));
      chk($sformatf("rdata k%0d", k), 32'(rdata), 32'(exp_rd));
      if (k == W + 2) got_b = b_ack;
    end
    if (!we) m_rdata = din;
    @(posedge clk); #1;
    chk_idle("post_turn");
  endtask

  initial begin
    bit g;
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    bus_din = '0;
    m_rdata = '0;
    m_last_b = 1'b1;

    #12;
    chk_idle("reset");
    chk("reset addr", 32'(bus_addr), 32'd0);
    chk("reset dout", 32'(bus_dout), 32'd0);
    #6 reset_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("after_reset");

    // Single write from A.
    a_req = 1; a_we = 1; a_addr = 16'hD020; a_wdata = 8'h0E;
    run_txn(1'b0, g);
    a_req = 0;

    // Single read from B.
    b_req = 1; b_we = 0; b_addr = 16'h1000; bus_din = 8'h5A;
    run_txn(1'b0, g);
    b_req = 0;
    chk("read 5a held", 32'(rdata), 32'h5A);

    // Write from A immediately followed by read from B.
    a_req = 1; a_we = 1; a_addr = 16'h2222; a_wdata = 8'hC3;
    run_txn(1'b0, g);
    a_req = 0; b_req = 1; b_we = 0; b_addr = 16'h3333; bus_din = 8'h96;
    run_txn(1'b0, g);
    b_req = 0;

    // Both requesting continuously for four transactions.
    a_req = 1; a_we = 1; a_addr = 16'hAAAA; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 16'hBBBB; b_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, g);
      chk($sformatf("tie grant %0d", i), 32'(g), FAIR ? 32'(i % 2) : 32'd0);
    end
    a_req = 0; b_req = 0;

    // Reset during the ACCESS phase of a write.
    a_req = 1; a_we = 1; a_addr = 16'h4444; a_wdata = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    m_rdata = '0;
    m_last_b = 1'b1;
    chk_idle("mid_reset");
    chk("mid_reset addr", 32'(bus_addr), 32'd0);
    a_req = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk_idle("held_reset");
    end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("released");
    b_req = 1; b_we = 0; b_addr = 16'h5555; bus_din = 8'hE1;
    run_txn(1'b0, g);
    b_req = 0;

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      int unsigned r;
      r = $urandom_range(1, 3);
      a_req = r[0]; b_req = r[1];
      a_we = 1'($urandom); b_we = 1'($urandom);
      a_addr = 16'($urandom); b_addr = 16'($urandom);
      a_wdata = 8'($urandom); b_wdata = 8'($urandom);
      bus_din = 8'($urandom);
      run_txn(1'($urandom), g);
      a_req = 0; b_req = 0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk_idle("rand_gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
